// File: rtl/freq_counter_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state encoding
// for the multi-channel frequency counter.
package freq_counter_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_GATE   = 8'h08;
    localparam logic [7:0] REG_COUNT0 = 8'h10;

    localparam int CTRL_CLR    = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_START  = 7;
    localparam int CTRL_EN_LSB = 8;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_OVF_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_GATE,
        ST_LATCH
    } fc_state_e;

endpackage

// File: rtl/fc_channel.sv
// One measurement channel: synchroniser, rising-edge detector, saturating counter.
// An edge is counted SYNC_STAGES+1 cycles after it arrives; ovf_o pulses on an edge lost to saturation.
module fc_channel #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sig_i,
    input  logic             clr_i,
    input  logic             cnt_en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_edge;
    logic                   w_sat;

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_sat  = &r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_i};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (cnt_en_i && w_edge && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;
    assign ovf_o = cnt_en_i & w_edge & w_sat & ~clr_i;

endmodule

// File: rtl/multichannel_freq_counter.sv
// Wishbone-attached multi-channel frequency counter: bus decode, registers, gate timer and FSM.
// Bus ack/err one cycle after request, never back-to-back; measurement windows are GATE cycles plus 2 dead cycles.
module multichannel_freq_counter
    import freq_counter_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        adr_i,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    input  logic              we_i,
    input  logic [3:0]        sel_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    output logic              ack_o,
    output logic              err_o,
    input  logic [NUM_CH-1:0] sig_i,
    output logic              irq_o
);

    localparam logic [5:0] LP_NCH = 6'(NUM_CH);

    logic              r_ack, r_err;
    logic [31:0]       r_dat;
    logic              r_cont, r_irq_en, r_start, r_clr;
    logic              r_done, r_irq;
    logic [NUM_CH-1:0] r_en, r_ovf;
    logic [31:0]       r_gate, r_gate_cnt;
    logic [CNT_W-1:0]  r_count [NUM_CH];
    fc_state_e         r_state, w_state_nxt;

    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_ovf_set, w_ovf_w1c;
    logic [7:0]        w_badr;
    logic [5:0]        w_cnt_idx;
    logic              w_is_cnt, w_adr_ok, w_req, w_bad, w_wr;
    logic              w_wr_ctrl, w_wr_status, w_wr_gate;
    logic              w_busy, w_ch_clr, w_gating;
    logic [31:0]       w_rdata;
    logic              w_unused_adr;

    assign w_unused_adr = ^adr_i[1:0];

    // Bus decode: one request per ack, so a held strobe is served every other cycle.
    assign w_badr      = {adr_i[7:2], 2'b00};
    assign w_cnt_idx   = adr_i[7:2] - 6'd4;
    assign w_is_cnt    = (adr_i[7:2] >= 6'd4) && (w_cnt_idx < LP_NCH);
    assign w_adr_ok    = (w_badr == REG_CTRL) || (w_badr == REG_STATUS) ||
                         (w_badr == REG_GATE) || w_is_cnt;
    assign w_req       = cyc_i & stb_i & ~r_ack & ~r_err;
    assign w_bad       = (sel_i != 4'hF) | ~w_adr_ok;
    assign w_wr        = w_req & we_i & ~w_bad;
    assign w_wr_ctrl   = w_wr && (w_badr == REG_CTRL);
    assign w_wr_status = w_wr && (w_badr == REG_STATUS);
    assign w_wr_gate   = w_wr && (w_badr == REG_GATE);

    assign w_busy      = (r_state != ST_IDLE);
    assign w_ch_clr    = (r_state == ST_ARM) | r_clr;
    assign w_gating    = (r_state == ST_GATE);
    assign w_ovf_w1c   = w_wr_status ? dat_i[STATUS_OVF_LSB +: NUM_CH] : '0;

    always_comb begin
        w_rdata = '0;
        if (w_badr == REG_CTRL) begin
            w_rdata[CTRL_CONT]               = r_cont;
            w_rdata[CTRL_IRQ_EN]             = r_irq_en;
            w_rdata[CTRL_EN_LSB +: NUM_CH]   = r_en;
        end else if (w_badr == REG_STATUS) begin
            w_rdata[STATUS_BUSY]             = w_busy;
            w_rdata[STATUS_DONE]             = r_done;
            w_rdata[STATUS_OVF_LSB +: NUM_CH] = r_ovf;
        end else if (w_badr == REG_GATE) begin
            w_rdata = r_gate;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (w_is_cnt && (w_cnt_idx == 6'(n))) begin
                    w_rdata[CNT_W-1:0] = r_count[n];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req & ~w_bad;
            r_err <= w_req & w_bad;
            r_dat <= (w_req && !w_bad && !we_i) ? w_rdata : '0;
        end
    end

    // CLR beats a START carried in the same write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cont   <= 1'b0;
            r_irq_en <= 1'b0;
            r_en     <= '0;
            r_start  <= 1'b0;
            r_clr    <= 1'b0;
            r_gate   <= '0;
        end else begin
            r_start <= 1'b0;
            r_clr   <= 1'b0;
            if (w_wr_ctrl) begin
                r_cont   <= dat_i[CTRL_CONT];
                r_irq_en <= dat_i[CTRL_IRQ_EN];
                r_en     <= dat_i[CTRL_EN_LSB +: NUM_CH];
                r_clr    <= dat_i[CTRL_CLR];
                r_start  <= dat_i[CTRL_START] & ~dat_i[CTRL_CLR];
            end
            if (w_wr_gate) begin
                r_gate <= dat_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (r_start && (r_gate != '0)) w_state_nxt = ST_ARM;
            ST_ARM:   w_state_nxt = ST_GATE;
            ST_GATE:  if (r_gate_cnt == 32'd1) w_state_nxt = ST_LATCH;
            ST_LATCH: w_state_nxt = r_cont ? ST_ARM : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (r_clr) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ARM) begin
                r_gate_cnt <= r_gate;
            end else if (r_state == ST_GATE) begin
                r_gate_cnt <= r_gate_cnt - 32'd1;
            end
        end
    end

    // Status flags: hardware set wins over a same-cycle W1C, CLR wins over both.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
            r_ovf  <= '0;
            r_irq  <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) r_count[n] <= '0;
        end else begin
            r_irq <= r_irq_en & r_done;
            if (r_clr) begin
                r_done <= 1'b0;
                r_ovf  <= '0;
                for (int n = 0; n < NUM_CH; n++) r_count[n] <= '0;
            end else begin
                r_ovf <= (r_ovf & ~w_ovf_w1c) | w_ovf_set;
                if (r_state == ST_LATCH) begin
                    r_done <= 1'b1;
                    for (int n = 0; n < NUM_CH; n++) begin
                        r_count[n] <= r_en[n] ? w_cnt[n] : '0;
                    end
                end else if (w_wr_status && dat_i[STATUS_DONE]) begin
                    r_done <= 1'b0;
                end
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        fc_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .sig_i    (sig_i[n]),
            .clr_i    (w_ch_clr),
            .cnt_en_i (w_gating & r_en[n]),
            .cnt_o    (w_cnt[n]),
            .ovf_o    (w_ovf_set[n])
        );
    end

    assign dat_o = r_dat;
    assign ack_o = r_ack;
    assign err_o = r_err;
    assign irq_o = r_irq;

endmodule

// File: doc/multichannel_freq_counter.md
# multichannel_freq_counter

Parametrised, multi-channel successor to the single-input frequency counter. Counts rising edges on `NUM_CH` asynchronous signal inputs over a common, programmable gate window measured in `clk_i` cycles. Supports single-shot and continuous measurement, per-channel saturation flags and a done interrupt. It sits on the Wishbone peripheral bus as a 32-bit slave.

## Interface
- `NUM_CH`, 4: number of input channels (1..8).
- `CNT_W`, 32: count register width (8..32). Results are zero-extended on read.
- `SYNC_STAGES`, 2: synchroniser flops per input (≥2).
- `clk_i`  in  1  system and Wishbone clock; the single clock of the block.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `adr_i`  in  8  byte address; `adr_i[1:0]` is ignored.
- `dat_i`  in  32  write data.
- `dat_o`  out  32  read data; valid while `ack_o`=1; reset value 0.
- `we_i`  in  1  write enable.
- `sel_i`  in  4  byte select; only 4'hF is legal.
- `cyc_i`, `stb_i`  in  1  bus cycle and strobe.
- `ack_o`  out  1  transfer acknowledge; reset value 0.
- `err_o`  out  1  error acknowledge; reset value 0.
- `sig_i`  in  NUM_CH  asynchronous measured signals.
- `irq_o`  out  1  level interrupt; reset value 0.

## Operation
Register map:
- 0x00 CTRL
  - bit0 CLR: self-clearing.
  - bit1 CONT.
  - bit2 IRQ_EN.
  - bit7 START: self-clearing.
  - bits[8+NUM_CH-1:8] EN: channel enable mask.
  - Reset value 0.
- 0x04 STATUS
  - bit0 BUSY: read-only.
  - bit1 DONE: write-1-to-clear.
  - bits[8+NUM_CH-1:8] OVF: sticky, write-1-to-clear.
- 0x08 GATE: gate length in `clk_i` cycles, 32 bits. Reset value 0.
- 0x10+4·n COUNT[n]: last latched result. Read-only.

Channel datapath:
- Synchroniser feeds a rising-edge detector.
- Working counter is incremented on each detected edge while the FSM is in GATE and EN[n]=1.
- Counter saturates at 2^CNT_W−1 and sets OVF[n].

FSM:
- IDLE: on START with GATE≠0 and CLR=0, go to ARM. START is ignored if GATE=0 or BUSY=1.
- ARM (1 cycle): clear the working counters, load the gate down-counter from GATE, go to GATE.
- GATE: decrement the down-counter each cycle. After exactly GATE cycles, go to LATCH.
- LATCH (1 cycle): copy working counts to COUNT[n] for enabled channels (disabled channels latch 0) and set DONE. If CONT=1 go to ARM, else go to IDLE.
- BUSY=1 in ARM, GATE and LATCH.

Boundary rules:
- CLR in any state: abort to IDLE, clear working counters, COUNT, DONE and OVF.
- CLR and START in the same write: CLR wins.
- Clearing CONT mid-window: the current window completes, then the FSM returns to IDLE.
- Writing GATE while BUSY: takes effect at the next ARM.
- Clearing DONE in the same cycle LATCH sets it: the set wins.
- `irq_o` is registered: `irq_o` = IRQ_EN & DONE, one cycle late.

## Timing
Bus:
- `ack_o`/`err_o` assert exactly one cycle after `cyc_i & stb_i` is seen, for one cycle.
- No back-to-back ack. A held strobe is re-acked every second cycle.
- `err_o` instead of `ack_o` for an unmapped address, COUNT[n] with n≥NUM_CH, or `sel_i`≠4'hF. An erroring write has no side effects.
- Register writes take effect on the ack cycle. START is seen by the FSM on the following cycle.

Measurement:
- An input edge is counted SYNC_STAGES+1 cycles after it arrives.
- The window is GATE consecutive `clk_i` cycles.
- There is a 2-cycle dead time (LATCH, ARM) between continuous windows. Edges in the dead time are not counted.
- Inputs must stay high and low for at least 1.5 `clk_i` periods each.

## Structure
- Package `freq_counter_pkg` holds:
  - register offsets;
  - CTRL/STATUS bit indices;
  - the FSM state enum (IDLE, ARM, GATE, LATCH).
- Sub-module `fc_channel`: synchroniser, edge detector and saturating counter with an OVF output. It is instantiated NUM_CH times via generate.
- Top level holds the bus decode, registers, gate down-counter and FSM.

## Test plan
All scenarios use a 10 ns `clk_i`.
- Single shot: `sig_i[0]` period 80 ns, GATE=800, EN=4'b0001, START → COUNT[0]=100 (±1), DONE=1, BUSY=0, COUNT[1..3]=0.
- Multi-channel: periods 80/40/200/20 ns, GATE=1000, EN=4'hF → COUNT = 125/250/50/500 (±1 each).
- Continuous: CONT=1, IRQ_EN=1, GATE=100, period 40 ns → `irq_o` rises about 102 cycles after START. Write-1 to DONE clears it, and it re-asserts every 102 cycles. Clearing CONT stops the block after the current window.
- Overflow: CNT_W=8, period 20 ns, GATE=1000 → COUNT[n]=255, OVF[n]=1. A W1C write to STATUS clears OVF.
- Abort/collisions:
  - CLR mid-GATE → BUSY=0, DONE=0, COUNT=0.
  - CLR|START in one write → no run.
  - START with GATE=0 → no run.
- Bus errors:
  - Read 0x40 with NUM_CH=4 → `err_o`=1, `ack_o`=0.
  - Write with `sel_i`=4'h3 → `err_o`=1, registers unchanged.
  - Reset mid-run (`rst_ni`=0) → all outputs 0 immediately.
